// File: rtl/cnn_pkg.sv
// cnn_pkg: fp32 helpers shared by the layers that avoid floating-point IP.
package cnn_pkg;

    localparam logic [31:0] FP_ZERO = 32'h0;

    function automatic logic [31:0] fp_relu(input logic [31:0] x);
        return x[31] ? FP_ZERO : x;
    endfunction

    // Both operands must be non-negative, so magnitude order equals fp order (positive NaN wins).
    function automatic logic [31:0] fp_max_pos(input logic [31:0] a, input logic [31:0] b);
        return (a[30:0] >= b[30:0]) ? a : b;
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// pool_line_buf: simple dual-port RAM holding one row of pair maxima; registered read, no content reset.
module pool_line_buf #(
    parameter int DEPTH = 128,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
        rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/relu_maxpool2x2.sv
// relu_maxpool2x2: ReLU followed by 2x2 stride-2 max pooling over a row-major fp32 pixel stream.
module relu_maxpool2x2
    import cnn_pkg::*;
#(
    parameter int C_WIDTH  = 9,
    parameter int C_LENGTH = 2*C_WIDTH,
    parameter int MAX_W    = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                param_ena,
    input  logic [C_WIDTH-1:0]  param_width,
    input  logic [C_LENGTH-1:0] param_length,
    input  logic                pxl_ena_z,
    input  logic [31:0]         pxl_z,
    output logic                pool_ena,
    output logic [31:0]         pool_data,
    output logic                frame_done,
    output logic                busy
);

    localparam int AW = $clog2(MAX_W/2);

    logic [C_WIDTH-1:0]  width_q, width_d, col_q, col_d;
    logic [C_LENGTH-1:0] length_q, length_d, pix_q, pix_d;
    logic                row_q, row_d, busy_q, busy_d;
    logic [31:0]         h_q, h_d, s1_pair_q, s1_pair_d, pool_data_q, pool_data_d;
    logic                s1_vld_q, s1_vld_d, s1_last_q, s1_last_d;
    logic                pool_ena_q, pool_ena_d, frame_done_q, frame_done_d;
    logic [31:0]         relu, pair, lb_rdata;
    logic                last_pix, col_last, odd, lb_we;
    logic [AW-1:0]       lb_addr;

    always_comb begin
        relu     = fp_relu(pxl_z);
        pair     = fp_max_pos(h_q, relu);
        last_pix = (pix_q + C_LENGTH'(1)) == length_q;
        col_last = col_q == (width_q - C_WIDTH'(1));
        odd      = col_q[0];
        lb_addr  = col_q[AW:1];
        lb_we    = pxl_ena_z & odd & ~row_q;
        width_d  = (param_ena & ~busy_q) ? param_width : width_q;
        length_d = (param_ena & ~busy_q) ? param_length : length_q;
        // The final pixel rewinds the counters at once so a pixel right behind it opens the next frame.
        col_d    = !pxl_ena_z ? col_q : (last_pix | col_last) ? '0 : col_q + C_WIDTH'(1);
        row_d    = !pxl_ena_z ? row_q : last_pix ? 1'b0 : row_q ^ col_last;
        pix_d    = !pxl_ena_z ? pix_q : last_pix ? '0 : pix_q + C_LENGTH'(1);
        h_d      = (pxl_ena_z & ~odd) ? relu : h_q;
        busy_d   = pxl_ena_z | (pix_q != '0);
        s1_vld_d  = pxl_ena_z & odd & row_q;
        s1_pair_d = (pxl_ena_z & odd) ? pair : s1_pair_q;
        s1_last_d = pxl_ena_z & last_pix;
        pool_ena_d   = s1_vld_q;
        pool_data_d  = s1_vld_q ? fp_max_pos(s1_pair_q, lb_rdata) : pool_data_q;
        frame_done_d = s1_last_q;
    end

    // Frame parameters survive reset so a frame can be replayed without reprogramming.
    always_ff @(posedge clk) begin
        width_q  <= width_d;
        length_q <= length_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= 1'b0;
            pix_q        <= '0;
            h_q          <= FP_ZERO;
            busy_q       <= 1'b0;
            s1_vld_q     <= 1'b0;
            s1_pair_q    <= FP_ZERO;
            s1_last_q    <= 1'b0;
            pool_ena_q   <= 1'b0;
            pool_data_q  <= FP_ZERO;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            pix_q        <= pix_d;
            h_q          <= h_d;
            busy_q       <= busy_d;
            s1_vld_q     <= s1_vld_d;
            s1_pair_q    <= s1_pair_d;
            s1_last_q    <= s1_last_d;
            pool_ena_q   <= pool_ena_d;
            pool_data_q  <= pool_data_d;
            frame_done_q <= frame_done_d;
        end
    end

    pool_line_buf #(.DEPTH(MAX_W/2), .AW(AW)) u_line_buf (
        .clk   (clk),
        .we    (lb_we),
        .waddr (lb_addr),
        .wdata (pair),
        .raddr (lb_addr),
        .rdata (lb_rdata)
    );

    assign pool_ena   = pool_ena_q;
    assign pool_data  = pool_data_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_relu_maxpool2x2.sv
// tb_relu_maxpool2x2: random and directed frames against a window-level pooling model with a scoreboard.
module tb_relu_maxpool2x2;

    logic        clk = 0, rst_n = 0, param_ena = 0, pxl_ena_z = 0;
    logic [8:0]  param_width = 0;
    logic [17:0] param_length = 0;
    logic [31:0] pxl_z = 0;
    logic        pool_ena, frame_done, busy;
    logic [31:0] pool_data;

    relu_maxpool2x2 dut (
        .clk(clk), .rst_n(rst_n), .param_ena(param_ena), .param_width(param_width),
        .param_length(param_length), .pxl_ena_z(pxl_ena_z), .pxl_z(pxl_z),
        .pool_ena(pool_ena), .pool_data(pool_data), .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [31:0] d; int t; } exp_t;
    exp_t        exp_q[$];
    exp_t        mon_e;
    int          done_q[$];
    int          mon_t;
    logic [31:0] frm [0:511];
    logic [31:0] last_data = 0;
    int          checks = 0, failures = 0;

    function automatic logic [31:0] relu(input logic [31:0] x);
        return x[31] ? 32'h0 : x;
    endfunction

    function automatic logic [31:0] mx(input logic [31:0] a, input logic [31:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(7, 0))
            0: return 32'h8000_0000;
            1: return 32'h7FC0_0000;
            2: return 32'hFFC0_0000;
            default: return $urandom();
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) last_data = 0;
        else begin
            if (pool_ena) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_pool: got %h expected no pulse", pool_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("pool_data", pool_data, mon_e.d);
                    check("pool_cycle", cyc, mon_e.t);
                end
                last_data = pool_data;
            end else check("pool_hold", pool_data, last_data);
            if (frame_done) begin
                if (done_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_done: got pulse at %0d expected none", cyc);
                end else begin
                    mon_t = done_q.pop_front();
                    check("done_cycle", cyc, mon_t);
                end
            end
        end
    end

    task automatic set_params(input int w, input int l);
        param_ena = 1; param_width = 9'(w); param_length = 18'(l);
        @(posedge clk); #1;
        param_ena = 0;
    endtask

    // Drives pixels first..last-1 of a w x h frame; windows close on odd-row, odd-column pixels.
    task automatic send_frame(input int w, input int h, input int gmax, input int first, input int last);
        for (int i = first; i < last; i++) begin
            int r, c;
            r = i / w; c = i % w;
            pxl_ena_z = 1; pxl_z = frm[i];
            if (r % 2 == 1 && c % 2 == 1) begin
                exp_t e;
                e.d = mx(mx(relu(frm[i-w-1]), relu(frm[i-w])), mx(relu(frm[i-1]), relu(frm[i])));
                e.t = cyc + 2;
                exp_q.push_back(e);
            end
            if (i == w*h - 1) done_q.push_back(cyc + 2);
            @(posedge clk); #1;
            pxl_ena_z = 0;
            repeat ($urandom_range(gmax, 0)) begin @(posedge clk); #1; end
        end
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 100 && (exp_q.size() != 0 || done_q.size() != 0); k++) begin
            @(posedge clk); #1;
        end
        if (exp_q.size() != 0 || done_q.size() != 0) begin
            failures++; checks++;
            $display("FAIL timeout: got %0d pools %0d dones outstanding expected 0", exp_q.size(), done_q.size());
            exp_q.delete(); done_q.delete();
        end
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic load_basic();
        frm[0] = 32'h3F80_0000; frm[1] = 32'h4000_0000; frm[2] = 32'h4040_0000; frm[3] = 32'hBF80_0000;
        frm[4] = 32'h3F00_0000; frm[5] = 32'h4080_0000; frm[6] = 32'hC000_0000; frm[7] = 32'h3F00_0000;
    endtask

    initial begin
        int w, h;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        check("rst_pool_ena", 32'(pool_ena), 0);
        check("rst_pool_data", pool_data, 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_busy", 32'(busy), 0);

        load_basic();
        set_params(4, 8);
        check("busy_idle", 32'(busy), 0);
        send_frame(4, 2, 0, 0, 1);
        check("busy_set", 32'(busy), 1);
        send_frame(4, 2, 0, 1, 8);
        wait_idle();
        check("busy_clear", 32'(busy), 0);

        for (int i = 0; i < 4; i++) frm[i] = 32'hBF80_0000;
        set_params(2, 4);
        send_frame(2, 2, 0, 0, 4);
        for (int i = 0; i < 4; i++) frm[i] = 32'h8000_0000;
        send_frame(2, 2, 0, 0, 4);
        wait_idle();

        for (int i = 0; i < 15; i++) frm[i] = $urandom() & 32'h7FFF_FFFF;
        set_params(5, 15);
        send_frame(5, 3, 0, 0, 15);
        wait_idle();

        load_basic();
        set_params(4, 8);
        repeat (3) send_frame(4, 2, 7, 0, 8);
        wait_idle();

        send_frame(4, 2, 0, 0, 5);
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        exp_q.delete(); done_q.delete();
        check("busy_after_rst", 32'(busy), 0);
        repeat (5) begin @(posedge clk); #1; end
        send_frame(4, 2, 2, 0, 8);
        wait_idle();

        send_frame(4, 2, 0, 0, 3);
        check("busy_mid", 32'(busy), 1);
        set_params(8, 16);
        send_frame(4, 2, 0, 3, 8);
        wait_idle();
        set_params(8, 16);
        for (int i = 0; i < 16; i++) frm[i] = rnd_val();
        send_frame(8, 2, 1, 0, 16);
        wait_idle();

        for (int n = 0; n < 6; n++) begin
            w = $urandom_range(9, 2); h = $urandom_range(4, 1);
            set_params(w, w*h);
            for (int rep = 0; rep < 2; rep++) begin
                for (int i = 0; i < w*h; i++) frm[i] = rnd_val();
                send_frame(w, h, rep * 2, 0, w*h);
            end
            wait_idle();
        end

        set_params(256, 512);
        for (int i = 0; i < 512; i++) frm[i] = rnd_val();
        send_frame(256, 2, 0, 0, 512);
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog: got no finish expected finish before 1ms");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
